// File: rtl/ps2_pkg.sv
// ============================================================================
// Module   : ps2_pkg
// Purpose  : Shared constants, parser states and event layout for ps2_kbd_ctrl
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

    localparam logic [7:0] SC_EXT  = 8'hE0;
    localparam logic [7:0] SC_BRK  = 8'hF0;
    localparam logic [7:0] SC_ERR0 = 8'h00;
    localparam logic [7:0] SC_ERR1 = 8'hFF;

    localparam int EVT_EXT = 9;
    localparam int EVT_BRK = 8;
    localparam int EVT_W   = 10;

    typedef enum logic [1:0] {
        BASE = 2'd0,
        E0   = 2'd1,
        F0   = 2'd2,
        E0F0 = 2'd3
    } ps_state_t;

    function automatic logic is_err_code(input logic [7:0] code);
        return (code == SC_ERR0) || (code == SC_ERR1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_evt_fifo.sv
// ============================================================================
// Module   : ps2_evt_fifo
// Purpose  : Show-ahead circular event queue; head reads as zero when empty
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = EVT_W
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     valid,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    assign valid = (count != '0);
    assign head  = valid ? mem[rd_ptr] : '0;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/ps2_kbd_ctrl.sv
// ============================================================================
// Module   : ps2_kbd_ctrl
// Purpose  : PS/2 set-2 scan-code sequencer: drains receiver, emits key events
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_kbd_ctrl
    import ps2_pkg::*;
#(
    parameter int EVT_DEPTH  = 4,
    parameter int PREFIX_TMO = 1000000
) (
    input  logic                        clk,
    input  logic                        clrn,
    input  logic [7:0]                  kbd_data,
    input  logic                        kbd_ready,
    input  logic                        kbd_overflow,
    output logic                        kbd_nextdata_n,
    output logic                        evt_valid,
    output logic [EVT_W-1:0]            evt_data,
    input  logic                        evt_pop,
    output logic [$clog2(EVT_DEPTH):0]  evt_count,
    output logic                        err,
    input  logic                        err_clr
);

    localparam int CW = $clog2(EVT_DEPTH) + 1;
    localparam int TW = $clog2(PREFIX_TMO + 1);

    ps_state_t          state;
    ps_state_t          nxt_state;
    logic [7:0]         byte_q;
    logic               byte_vld;
    logic [TW-1:0]      tmo_cnt;
    logic               space_ok;
    logic               push;
    logic [EVT_W-1:0]   push_data;
    logic               parse_err;
    logic               tmo_hit;

    // A byte still in the capture stage may yet need a slot, so it is reserved.
    assign space_ok = ({1'b0, evt_count} + {{CW{1'b0}}, byte_vld}) < (CW+1)'(EVT_DEPTH);
    assign kbd_nextdata_n = ~(clrn & kbd_ready & space_ok);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            byte_q   <= '0;
            byte_vld <= 1'b0;
        end else begin
            byte_vld <= ~kbd_nextdata_n;
            if (!kbd_nextdata_n) byte_q <= kbd_data;
        end
    end

    always_comb begin
        nxt_state = state;
        push      = 1'b0;
        parse_err = 1'b0;
        tmo_hit   = 1'b0;
        if (byte_vld) begin
            case (state)
                BASE: begin
                    if (byte_q == SC_EXT)        nxt_state = E0;
                    else if (byte_q == SC_BRK)   nxt_state = F0;
                    else if (is_err_code(byte_q)) parse_err = 1'b1;
                    else                          push      = 1'b1;
                end
                E0: begin
                    if (byte_q == SC_BRK) begin
                        nxt_state = E0F0;
                    end else begin
                        nxt_state = BASE;
                        if (byte_q == SC_EXT) parse_err = 1'b1;
                        else                  push      = 1'b1;
                    end
                end
                default: begin
                    nxt_state = BASE;
                    if (byte_q == SC_EXT || byte_q == SC_BRK || is_err_code(byte_q))
                        parse_err = 1'b1;
                    else
                        push = 1'b1;
                end
            endcase
        end else if (state != BASE && tmo_cnt == TW'(PREFIX_TMO - 1)) begin
            tmo_hit   = 1'b1;
            nxt_state = BASE;
        end
    end

    assign push_data = {(state == E0) || (state == E0F0),
                        (state == F0) || (state == E0F0),
                        byte_q};

    // Counter restarts whenever a byte is parsed or the parser is back in BASE.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= BASE;
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            state <= nxt_state;
            if (byte_vld || nxt_state == BASE) tmo_cnt <= '0;
            else                               tmo_cnt <= tmo_cnt + TW'(1);
            err <= kbd_overflow | parse_err | tmo_hit | (err & ~err_clr);
        end
    end

    ps2_evt_fifo #(
        .DEPTH (EVT_DEPTH),
        .WIDTH (EVT_W)
    ) u_evt_fifo (
        .clk       (clk),
        .clrn      (clrn),
        .push      (push),
        .push_data (push_data),
        .pop       (evt_pop),
        .valid     (evt_valid),
        .head      (evt_data),
        .count     (evt_count)
    );

endmodule

`default_nettype wire

// File: tb/tb_ps2_kbd_ctrl.sv
// ============================================================================
// Module   : tb_ps2_kbd_ctrl
// Purpose  : Directed self-checking bench for ps2_kbd_ctrl with a receiver model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_kbd_ctrl;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic [7:0] kbd_data = 8'h00;
    logic       kbd_ready = 1'b0;
    logic       kbd_overflow = 1'b0;
    logic       evt_pop = 1'b0;
    logic       err_clr = 1'b0;
    logic       kbd_nextdata_n;
    logic       evt_valid;
    logic [9:0] evt_data;
    logic [2:0] evt_count;
    logic       err;

    int errors = 0;
    int checks = 0;
    int pop_cnt = 0;
    int done_cnt = 0;
    logic [7:0] rx_q[$];

    ps2_kbd_ctrl #(
        .EVT_DEPTH  (DEPTH),
        .PREFIX_TMO (TMO)
    ) dut (
        .clk            (clk),
        .clrn           (clrn),
        .kbd_data       (kbd_data),
        .kbd_ready      (kbd_ready),
        .kbd_overflow   (kbd_overflow),
        .kbd_nextdata_n (kbd_nextdata_n),
        .evt_valid      (evt_valid),
        .evt_data       (evt_data),
        .evt_pop        (evt_pop),
        .evt_count      (evt_count),
        .err            (err),
        .err_clr        (err_clr)
    );

    always #5 clk = ~clk;

    // Receiver model: bytes consumed at a rising edge leave the FIFO by the next falling edge.
    always @(posedge clk) begin
        if (!kbd_nextdata_n) pop_cnt <= pop_cnt + 1;
    end

    always @(negedge clk) begin
        while (done_cnt < pop_cnt) begin
            if (rx_q.size() > 0) rx_q.delete(0);
            done_cnt++;
        end
        kbd_ready = (rx_q.size() != 0);
        kbd_data  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] b);
        rx_q.push_back(b);
    endtask

    task automatic do_pop();
        evt_pop = 1'b1;
        tick(1);
        evt_pop = 1'b0;
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        tick(2);
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", evt_valid); end
        checks++; if (evt_data !== 10'h000) begin errors++; $display("FAIL reset_data: got %h expected 000", evt_data); end
        checks++; if (evt_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", evt_count); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (kbd_nextdata_n !== 1'b1) begin errors++; $display("FAIL reset_nextdata: got %b expected 1", kbd_nextdata_n); end
        clrn = 1'b1;
        tick(2);
    endtask

    task automatic test_make();
        int p0;
        p0 = pop_cnt;
        feed(8'h1C);
        @(negedge clk); #1;
        checks++; if (kbd_nextdata_n !== 1'b0) begin errors++; $display("FAIL make_pop_c0: got %b expected 0", kbd_nextdata_n); end
        @(posedge clk); #1;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL make_valid_c1: got %b expected 0", evt_valid); end
        checks++; if (pop_cnt - p0 !== 1) begin errors++; $display("FAIL make_pops: got %0d expected 1", pop_cnt - p0); end
        @(posedge clk); #1;
        checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL make_valid_c2: got %b expected 1", evt_valid); end
        checks++; if (evt_data !== 10'h01C) begin errors++; $display("FAIL make_data: got %h expected 01c", evt_data); end
        checks++; if (evt_count !== 3'd1) begin errors++; $display("FAIL make_count: got %0d expected 1", evt_count); end
        do_pop();
        checks++; if (evt_count !== 3'd0) begin errors++; $display("FAIL make_pop_count: got %0d expected 0", evt_count); end
    endtask

    task automatic test_ext_break();
        int p0;
        p0 = pop_cnt;
        feed(8'hE0); feed(8'hF0); feed(8'h75);
        tick(3);
        checks++; if (evt_count !== 3'd0) begin errors++; $display("FAIL extbrk_prefix_noevt: got %0d expected 0", evt_count); end
        tick(5);
        checks++; if (pop_cnt - p0 !== 3) begin errors++; $display("FAIL extbrk_pops: got %0d expected 3", pop_cnt - p0); end
        checks++; if (evt_count !== 3'd1) begin errors++; $display("FAIL extbrk_count: got %0d expected 1", evt_count); end
        checks++; if (evt_data !== 10'h375) begin errors++; $display("FAIL extbrk_data: got %h expected 375", evt_data); end
        do_pop();
    endtask

    task automatic test_backpressure();
        int p0;
        p0 = pop_cnt;
        feed(8'h16); feed(8'h1E); feed(8'h26); feed(8'h25); feed(8'h2E); feed(8'h36);
        tick(15);
        checks++; if (pop_cnt - p0 !== 4) begin errors++; $display("FAIL bp_pops: got %0d expected 4", pop_cnt - p0); end
        checks++; if (evt_count !== 3'd4) begin errors++; $display("FAIL bp_count: got %0d expected 4", evt_count); end
        checks++; if (kbd_ready !== 1'b1 || kbd_nextdata_n !== 1'b1) begin errors++; $display("FAIL bp_hold: got ready=%b nextdata_n=%b expected 1/1", kbd_ready, kbd_nextdata_n); end
        checks++; if (evt_data !== 10'h016) begin errors++; $display("FAIL bp_head: got %h expected 016", evt_data); end
        do_pop();
        tick(6);
        checks++; if (pop_cnt - p0 !== 5) begin errors++; $display("FAIL bp_pops_after: got %0d expected 5", pop_cnt - p0); end
        checks++; if (evt_count !== 3'd4) begin errors++; $display("FAIL bp_count_after: got %0d expected 4", evt_count); end
        checks++; if (evt_data !== 10'h01E) begin errors++; $display("FAIL bp_head_after: got %h expected 01e", evt_data); end
        repeat (8) begin do_pop(); tick(2); end
        checks++; if (pop_cnt - p0 !== 6) begin errors++; $display("FAIL bp_pops_total: got %0d expected 6", pop_cnt - p0); end
        checks++; if (evt_count !== 3'd0 || evt_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got count=%0d valid=%b expected 0/0", evt_count, evt_valid); end
    endtask

    task automatic test_errors();
        int p0;
        p0 = pop_cnt;
        feed(8'hF0); feed(8'hE0);
        tick(6);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_f0e0: got %b expected 1", err); end
        checks++; if (evt_count !== 3'd0) begin errors++; $display("FAIL err_f0e0_noevt: got %0d expected 0", evt_count); end
        checks++; if (pop_cnt - p0 !== 2) begin errors++; $display("FAIL err_f0e0_pops: got %0d expected 2", pop_cnt - p0); end
        feed(8'h1C);
        tick(6);
        checks++; if (evt_data !== 10'h01C || evt_count !== 3'd1) begin errors++; $display("FAIL err_base_after: got data=%h count=%0d expected 01c/1", evt_data, evt_count); end
        do_pop();
        err_clr = 1'b1; kbd_overflow = 1'b1;
        tick(1);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set_wins: got %b expected 1", err); end
        kbd_overflow = 1'b0;
        tick(1);
        err_clr = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", err); end
        feed(8'h00);
        tick(6);
        checks++; if (err !== 1'b1 || evt_count !== 3'd0) begin errors++; $display("FAIL err_code00: got err=%b count=%0d expected 1/0", err, evt_count); end
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    task automatic test_timeout();
        feed(8'hE0);
        tick(10);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b expected 0", err); end
        tick(10);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b expected 1", err); end
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        feed(8'h1C);
        tick(5);
        checks++; if (evt_data !== 10'h01C || evt_count !== 3'd1) begin errors++; $display("FAIL tmo_next: got data=%h count=%0d expected 01c/1", evt_data, evt_count); end
        do_pop();
    endtask

    task automatic test_reset_mid();
        feed(8'h1C); feed(8'h2C); feed(8'hE0);
        tick(7);
        checks++; if (evt_count !== 3'd2) begin errors++; $display("FAIL rstmid_pre_count: got %0d expected 2", evt_count); end
        kbd_overflow = 1'b1;
        tick(1);
        kbd_overflow = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL rstmid_ovf: got %b expected 1", err); end
        clrn = 1'b0;
        feed(8'h1C);
        #1;
        checks++; if (evt_valid !== 1'b0 || evt_data !== 10'h000 || evt_count !== 3'd0 || err !== 1'b0) begin
            errors++; $display("FAIL rstmid_outputs: got valid=%b data=%h count=%0d err=%b expected 0/000/0/0", evt_valid, evt_data, evt_count, err);
        end
        @(negedge clk); #1;
        checks++; if (kbd_ready !== 1'b1 || kbd_nextdata_n !== 1'b1) begin errors++; $display("FAIL rstmid_nextdata: got ready=%b nextdata_n=%b expected 1/1", kbd_ready, kbd_nextdata_n); end
        @(posedge clk); #1;
        clrn = 1'b1;
        tick(5);
        checks++; if (evt_data !== 10'h01C || evt_count !== 3'd1) begin errors++; $display("FAIL rstmid_after: got data=%h count=%0d expected 01c/1", evt_data, evt_count); end
        do_pop();
    endtask

    initial begin
        test_reset();
        test_make();
        test_ext_break();
        test_backpressure();
        test_errors();
        test_timeout();
        test_reset_mid();
        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/ps2_kbd_ctrl.md
# ps2_kbd_ctrl

Scan-code sequencer that sits between the PS/2 keyboard receiver FIFO and the CPU-side peripheral bus. Drains received bytes through the receiver's ready/nextdata_n handshake and parses the set-2 prefix bytes 0xE0 and 0xF0. Emits one decoded key event per make/break code into a small show-ahead event queue. Provides flow control, a sticky error flag and a prefix timeout, so software only ever sees complete key events.

## Interface
Parameters:
- EVT_DEPTH, 4: event queue depth; power of two, ≥ 2.
- PREFIX_TMO, 1000000: maximum clk cycles spent in a prefix state before it is abandoned.

Ports:
- clk  in  1  system clock.
- clrn  in  1  reset; asynchronous, active-low.
- kbd_data  in  8  head-of-FIFO scan code from the receiver; valid while kbd_ready=1.
- kbd_ready  in  1  receiver FIFO non-empty.
- kbd_overflow  in  1  receiver FIFO overflow flag (level).
- kbd_nextdata_n  out  1  active-low pop strobe to the receiver; one cycle low per byte consumed.
- evt_valid  out  1  event queue non-empty.
- evt_data  out  10  head event: [9]=extended (E0 seen), [8]=break (F0 seen), [7:0]=code.
- evt_pop  in  1  consume the head event; ignored when evt_valid=0.
- evt_count  out  $clog2(EVT_DEPTH)+1  current queue occupancy.
- err  out  1  sticky error.
- err_clr  in  1  clears err.

## Operation
- Pop rule: kbd_nextdata_n = ~(clrn & kbd_ready & (evt_count + byte_vld < EVT_DEPTH)). The output is combinational. A byte is consumed only if its event is guaranteed a queue slot.
- Capture stage: in a pop cycle, kbd_data is registered into byte_q and byte_vld is set for one cycle. Back-to-back pops are legal, because the receiver updates ready and data on the same edge.
- Parser FSM. It advances only when byte_vld=1, except for the timeout.
  - BASE:
    - E0 -> E0.
    - F0 -> F0.
    - 00 or FF -> set err, stay in BASE, no event.
    - Any other byte -> push {0,0,code}, stay in BASE.
  - E0:
    - F0 -> E0F0.
    - E0 -> set err, go to BASE.
    - Any other byte -> push {1,0,code}, go to BASE.
  - F0:
    - E0, F0, 00 or FF -> set err, go to BASE, no event.
    - Any other byte -> push {0,1,code}, go to BASE.
  - E0F0:
    - E0, F0, 00 or FF -> set err, go to BASE, no event.
    - Any other byte -> push {1,1,code}, go to BASE.
- Prefix timeout:
  - A counter is cleared on entry to any prefix state and increments each cycle in which no byte is parsed.
  - When the counter reaches PREFIX_TMO-1: go to BASE and set err.
  - A byte parsed in that same cycle takes priority over the timeout.
- Event queue:
  - Circular, show-ahead; evt_data always equals the head entry.
  - Push and pop in the same cycle leave the count unchanged.
  - A push can never hit a full queue, because the pop rule prevents it.
  - Pointers wrap modulo EVT_DEPTH.
- err:
  - Set by: kbd_overflow=1 in any cycle, a parse error, or a timeout.
  - Cleared by err_clr.
  - If set and clear occur in the same cycle, set wins.
- Reset (async assert, sync deassert handled upstream):
  - State: FSM=BASE, byte_vld=0, queue empty, pointers 0, timeout counter 0.
  - Outputs: evt_valid=0, evt_data=0, evt_count=0, err=0, kbd_nextdata_n=1.
  - A prefix state or queued event in progress is discarded.

## Timing
- Byte at the FIFO head with kbd_ready=1 in cycle 0: kbd_nextdata_n is low in cycle 0, byte_q is valid in cycle 1, and the event is visible (evt_valid=1) in cycle 2.
- A prefix-only byte produces no event and occupies the capture stage for one cycle.
- evt_pop in cycle n: evt_data shows the next entry and evt_count decrements in cycle n+1.
- Sustained throughput is one byte per cycle while the queue has space.

## Structure
- Shared package ps2_pkg:
  - Constants: SC_EXT=8'hE0, SC_BRK=8'hF0, SC_ERR0=8'h00, SC_ERR1=8'hFF.
  - Parser state enum {BASE, E0, F0, E0F0}.
  - Event field positions EVT_EXT=9, EVT_BRK=8.
- One sub-module, ps2_evt_fifo: parameterized show-ahead queue with push, pop, head, count and async active-low reset.
- Capture stage, parser FSM, timeout counter and err logic live in ps2_kbd_ctrl.

## Test plan
- Make: feed 1C (A make).
  - nextdata_n low in cycle 0; evt_valid in cycle 2; evt_data=0x01C; evt_count=1.
- Extended break: feed E0 F0 75 back-to-back.
  - Three pops, one event 0x375.
  - Bytes 1 and 2 produce no events.
- Backpressure: EVT_DEPTH=4, feed six makes, no evt_pop.
  - Exactly four pops; kbd_nextdata_n then held high with kbd_ready=1.
  - evt_count=4.
  - After one evt_pop, exactly one more byte is consumed.
- Errors:
  - Feed F0 E0: err=1, FSM=BASE, no event.
  - err_clr together with kbd_overflow=1: err stays 1.
  - err_clr alone: err=0.
- Timeout: PREFIX_TMO=16, feed E0 then idle.
  - err set after 16 cycles.
  - A following 1C yields 0x01C, not extended.
- Reset mid-stream: assert clrn low while in state E0 with two events queued.
  - All outputs at reset values immediately.
  - After release, a 1C yields 0x01C.
